// File: rtl/writeback_arbiter.sv
// Round-robin merge of ALU and LSU results onto the register-file write port,
// with a pending-write scoreboard for RAW hazard detection at issue.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } wb_ent_t;

  wb_ent_t         mem [2][FIFO_DEPTH];
  logic [PW:0]     wptr [2];
  logic [PW:0]     rptr [2];
  logic [1:0]      empty;
  logic [1:0]      full;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic            any_pop;
  logic            sel;
  logic            last_grant;
  wb_ent_t         head;
  wb_ent_t         alu_ent;
  wb_ent_t         lsu_ent;
  logic [NREG-1:0] pending;

  assign alu_ent = '{rd: alu_rd, data: alu_data};
  assign lsu_ent = '{rd: lsu_rd, data: lsu_data};

  always_comb begin
    empty = '0;
    full  = '0;
    for (int s = 0; s < 2; s++) begin
      empty[s] = (wptr[s] == rptr[s]);
      full[s]  = (wptr[s][PW] != rptr[s][PW]) &&
                 (wptr[s][PW-1:0] == rptr[s][PW-1:0]);
    end
  end

  assign alu_ready = !full[0];
  assign lsu_ready = !full[1];
  assign push[0]   = alu_valid && !full[0];
  assign push[1]   = lsu_valid && !full[1];

  // Tie goes to whichever source did not win the previous pop.
  always_comb begin
    any_pop = 1'b0;
    sel     = SRC_ALU;
    unique case (1'b1)
      (!empty[0] && !empty[1]): begin
        any_pop = 1'b1;
        sel     = (last_grant == SRC_ALU) ? SRC_LSU : SRC_ALU;
      end
      (empty[0] && !empty[1]): begin
        any_pop = 1'b1;
        sel     = SRC_LSU;
      end
      (!empty[0] && empty[1]): begin
        any_pop = 1'b1;
        sel     = SRC_ALU;
      end
      default: begin
        any_pop = 1'b0;
        sel     = SRC_ALU;
      end
    endcase
    pop  = '0;
    pop[0] = any_pop && (sel == SRC_ALU);
    pop[1] = any_pop && (sel == SRC_LSU);
    head = sel ? mem[1][rptr[1][PW-1:0]]
               : mem[0][rptr[0][PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push[0]) mem[0][wptr[0][PW-1:0]] <= alu_ent;
    if (push[1]) mem[1][wptr[1][PW-1:0]] <= lsu_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wptr[s] <= wptr[s] + 1'b1;
        if (pop[s])  rptr[s] <= rptr[s] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      last_grant <= SRC_ALU;
    end else if (any_pop) begin
      wb_we      <= (head.rd != '0);
      wb_addr    <= head.rd;
      wb_data    <= head.data;
      last_grant <= sel;
    end else begin
      wb_we <= 1'b0;
    end
  end

  // Set after clear so a same-edge reissue keeps the register pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (any_pop && head.rd != '0)
        pending[head.rd] <= 1'b0;
      if (issue_valid && issue_rd != '0)
        pending[issue_rd] <= 1'b1;
    end
  end

  assign rs1_busy = (chk_rs1 != '0) &&
                    (pending[chk_rs1] || (wb_we && wb_addr == chk_rs1));
  assign rs2_busy = (chk_rs2 != '0) &&
                    (pending[chk_rs2] || (wb_we && wb_addr == chk_rs2));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares each wb_we cycle.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd, chk_rs1, chk_rs2;
  logic        rs1_busy, rs2_busy;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  writeback_arbiter #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  always @(negedge clk) begin
    if (mon_en && wb_we) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write",
                 wb_addr, wb_data);
      end else begin
        chk("wb_write", {27'd0, wb_addr, wb_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int ai, li;
    bit a_acc, l_acc, saw_bp;
    reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    tick();
    tick();
    chk("rst_we", wb_we, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_ready", {alu_ready, lsu_ready}, 2'b11);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // single ALU write latency and hold
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    expect_wb(5, 32'hDEADBEEF);
    tick();
    alu_valid = 0;
    chk("t1_no_bypass", wb_we, 0);
    tick();
    chk("t1_we", wb_we, 1);
    chk("t1_addr", wb_addr, 5);
    chk("t1_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("t1_we_drop", wb_we, 0);
    chk("t1_hold", {wb_addr, wb_data}, {5'd5, 32'hDEADBEEF});

    // tie: LSU first, and again on the next tie
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    expect_wb(2, 32'h22);
    expect_wb(1, 32'h11);
    tick();
    alu_valid = 0; lsu_valid = 0;
    tick();
    chk("t2_first_lsu", wb_addr, 2);
    tick();
    chk("t2_then_alu", wb_addr, 1);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    expect_wb(4, 32'h44);
    expect_wb(3, 32'h33);
    tick();
    alu_valid = 0; lsu_valid = 0;
    tick();
    chk("t2_tie2_lsu", wb_addr, 4);
    tick();
    chk("t2_tie2_alu", wb_addr, 3);
    tick();

    // both sources streaming: strict LSU/ALU alternation
    for (int i = 0; i < 4; i++) begin
      expect_wb(5'(16 + i), 32'hB000_0000 + i);
      expect_wb(5'(8 + i), 32'hA000_0000 + i);
    end
    ai = 0; li = 0; saw_bp = 0;
    alu_valid = 1; alu_rd = 8;  alu_data = 32'hA000_0000;
    lsu_valid = 1; lsu_rd = 16; lsu_data = 32'hB000_0000;
    for (int c = 0; c < 12 && (ai < 4 || li < 4); c++) begin
      a_acc = alu_valid && alu_ready;
      l_acc = lsu_valid && lsu_ready;
      if (!alu_ready || !lsu_ready) saw_bp = 1;
      tick();
      if (c >= 1) chk("t3_we_cont", wb_we, 1);
      if (a_acc) ai++;
      if (l_acc) li++;
      alu_valid = (ai < 4); alu_rd = 5'(8 + ai);
      alu_data = 32'hA000_0000 + ai;
      lsu_valid = (li < 4); lsu_rd = 5'(16 + li);
      lsu_data = 32'hB000_0000 + li;
    end
    alu_valid = 0; lsu_valid = 0;
    chk("t3_all_sent", {ai[7:0], li[7:0]}, {8'd4, 8'd4});
    chk("t3_backpressure", saw_bp, 1);
    repeat (4) tick();

    // x0 writes are consumed silently
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    chk_rs1 = 5;
    tick();
    alu_valid = 0;
    chk("t4_we_e1", wb_we, 0);
    tick();
    chk("t4_we_e2", wb_we, 0);
    chk("t4_popped", wb_data, 32'hFFFFFFFF);
    chk("t4_busy", {rs1_busy, rs2_busy}, 2'b00);
    tick();
    chk("t4_ready", alu_ready, 1);

    // scoreboard set/clear and set-wins
    chk_rs1 = 7; chk_rs2 = 7;
    issue_valid = 1; issue_rd = 7;
    chk("t5_busy_pre", rs1_busy, 0);
    tick();
    issue_valid = 0;
    chk("t5_busy_set", rs1_busy, 1);
    chk("t5_busy2_set", rs2_busy, 1);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    expect_wb(7, 32'h77);
    tick();
    alu_valid = 0;
    chk("t5_busy_q", rs1_busy, 1);
    tick();
    chk("t5_busy_wb", {wb_we, rs1_busy}, 2'b11);
    tick();
    chk("t5_busy_clr", rs1_busy, 0);
    chk_rs2 = 0;
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    expect_wb(7, 32'h78);
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    tick();
    chk("t5_set_wins", {wb_we, rs1_busy}, 2'b01);
    chk("t5_rs2_x0", rs2_busy, 0);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h79;
    expect_wb(7, 32'h79);
    tick();
    alu_valid = 0;
    tick();
    tick();
    chk("t5_busy_final", rs1_busy, 0);

    // mid-cycle reset with queued entries
    issue_valid = 1; issue_rd = 9; chk_rs1 = 9;
    tick();
    issue_valid = 0;
    mon_en = 1'b0;
    alu_valid = 1; alu_rd = 12; alu_data = 32'hC1;
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'hD1;
    tick();
    alu_data = 32'hC2; lsu_data = 32'hD2;
    tick();
    alu_valid = 0; lsu_valid = 0;
    chk("t6_pre_we", wb_we, 1);
    chk("t6_pre_busy", rs1_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_we", wb_we, 0);
    chk("t6_rst_ready", {alu_ready, lsu_ready}, 2'b11);
    chk("t6_rst_busy", rs1_busy, 0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_write", wb_we, 0);
    end
    chk("t6_busy_after", rs1_busy, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
